// File: rtl/aes_pkg.sv
// Shared AES definitions for the InvMixColumns datapath: FSM states, GF(2^8) constants, xtime helper.
package aes_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned COL_W   = 32;
    localparam int unsigned STATE_W = 128;
    localparam int unsigned COL_IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fsm_t;

    // Inverse MixColumns row 0 coefficients; the other rows are rotations of this one.
    localparam logic [BYTE_W-1:0] INV_COEF_0E = 8'h0e;
    localparam logic [BYTE_W-1:0] INV_COEF_0B = 8'h0b;
    localparam logic [BYTE_W-1:0] INV_COEF_0D = 8'h0d;
    localparam logic [BYTE_W-1:0] INV_COEF_09 = 8'h09;

    // Low byte of the reduction polynomial x^8+x^4+x^3+x+1.
    localparam logic [BYTE_W-1:0] GF_POLY = 8'h1b;

    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
        xtime = {b[BYTE_W-2:0], 1'b0} ^ (b[BYTE_W-1] ? GF_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/inv_calculate_column.sv
// Combinational InvMixColumns of one 32-bit column (row r in bits [8r+7:8r]).
module inv_calculate_column
    import aes_pkg::*;
(
    input  logic [COL_W-1:0] col,
    output logic [COL_W-1:0] mixed
);

    // Multiply by one of the four inverse coefficients using a shared xtime chain.
    function automatic logic [BYTE_W-1:0] gf_mul(input logic [BYTE_W-1:0] b,
                                                 input logic [BYTE_W-1:0] k);
        logic [BYTE_W-1:0] x2;
        logic [BYTE_W-1:0] x4;
        logic [BYTE_W-1:0] x8;
        logic [BYTE_W-1:0] r;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        r  = 8'h00;
        case (k)
            INV_COEF_09: r = x8 ^ b;
            INV_COEF_0B: r = x8 ^ x2 ^ b;
            INV_COEF_0D: r = x8 ^ x4 ^ b;
            INV_COEF_0E: r = x8 ^ x4 ^ x2;
            default:     r = 8'h00;
        endcase
        gf_mul = r;
    endfunction

    logic [BYTE_W-1:0] b [4];

    for (genvar i = 0; i < 4; i++) begin : g_split
        assign b[i] = col[i*BYTE_W +: BYTE_W];
    end

    // Row r applies {0e,0b,0d,09} starting at byte r, wrapping around the column.
    for (genvar r = 0; r < 4; r++) begin : g_row
        assign mixed[r*BYTE_W +: BYTE_W] = gf_mul(b[r],           INV_COEF_0E)
                                         ^ gf_mul(b[(r + 1) % 4], INV_COEF_0B)
                                         ^ gf_mul(b[(r + 2) % 4], INV_COEF_0D)
                                         ^ gf_mul(b[(r + 3) % 4], INV_COEF_09);
    end

endmodule

// File: rtl/inv_mix_columns.sv
// AES InvMixColumns over a full 128-bit state, one column per clock through a shared column unit.
module inv_mix_columns
    import aes_pkg::*;
(
    input  logic               pi_clk,
    input  logic               pi_rst,
    input  logic               pi_in_valid,
    output logic               po_in_ready,
    input  logic [STATE_W-1:0] pi_state,
    output logic               po_out_valid,
    input  logic               pi_out_ready,
    output logic [STATE_W-1:0] po_state,
    output logic               po_busy
);

    fsm_t                 state;
    logic [STATE_W-1:0]   cap;
    logic [COL_IDX_W-1:0] col_cnt;
    logic                 issued;
    logic [COL_W-1:0]     col_q;
    logic [COL_IDX_W-1:0] col_q_idx;
    logic                 col_q_vld;
    logic [COL_W-1:0]     col_res;

    inv_calculate_column u_col (
        .col   (col_q),
        .mixed (col_res)
    );

    // Column fetch is registered one stage ahead of the write-back, so CALC spans five edges.
    always_ff @(posedge pi_clk or posedge pi_rst) begin
        if (pi_rst) begin
            state        <= IDLE;
            cap          <= '0;
            col_cnt      <= '0;
            issued       <= 1'b0;
            col_q        <= '0;
            col_q_idx    <= '0;
            col_q_vld    <= 1'b0;
            po_state     <= '0;
            po_in_ready  <= 1'b1;
            po_out_valid <= 1'b0;
            po_busy      <= 1'b0;
        end else begin
            col_q_vld <= 1'b0;
            if (col_q_vld) begin
                po_state[{col_q_idx, 5'd0} +: COL_W] <= col_res;
            end
            case (state)
                IDLE: begin
                    if (pi_in_valid) begin
                        cap         <= pi_state;
                        col_cnt     <= '0;
                        issued      <= 1'b0;
                        state       <= CALC;
                        po_in_ready <= 1'b0;
                        po_busy     <= 1'b1;
                    end
                end
                CALC: begin
                    if (!issued) begin
                        col_q     <= cap[{col_cnt, 5'd0} +: COL_W];
                        col_q_idx <= col_cnt;
                        col_q_vld <= 1'b1;
                        col_cnt   <= col_cnt + 2'd1;
                        if (col_cnt == 2'd3) begin
                            issued <= 1'b1;
                        end
                    end else begin
                        state        <= DONE;
                        po_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (pi_out_ready) begin
                        state        <= IDLE;
                        po_out_valid <= 1'b0;
                        po_in_ready  <= 1'b1;
                        po_busy      <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    po_out_valid <= 1'b0;
                    po_in_ready  <= 1'b1;
                    po_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
